// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-to-1 stream merge.
//   NUM_CH      : number of merged channels (fixed at 4)
//   SEL_W       : width of a channel index
//   arb_state_e : IDLE (free arbitration) / LOCKED (mid-packet on lock_ch)
//   inc_wrap    : 2-bit wrapping increment used for the round-robin pointer
package mux4_arb_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

  // 3 + 1 wraps to 0 naturally at SEL_W bits.
  function automatic logic [SEL_W-1:0] inc_wrap(input logic [SEL_W-1:0] v);
    return v + SEL_W'(1);
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over 4 requesters.
//   req     : request vector, bit k = channel k
//   ptr     : highest-priority channel this cycle
//   gnt_idx : first requesting channel scanning ptr, ptr+1, ... (mod 4)
//   gnt_any : at least one request present (gnt_idx only meaningful then)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  // Scan from the farthest offset down so the nearest requester to ptr
  // is the last (winning) assignment.
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        gnt_idx = ptr + SEL_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_1_stream_arb.sv
// 4-to-1 valid/ready stream merge with packet-granular round-robin
// arbitration and a single registered output slot. Each output beat is
// tagged with its source channel so a downstream demux can re-steer it.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_data/in_last : four input streams (channel k at bit k /
//                          data bits [k*DATA_W +: DATA_W])
//   in_ready             : per-channel accept, one-hot or zero
//   out_valid/out_data/out_last/out_sel : registered output beat + source
//   out_ready            : downstream accept
module mux4_1_stream_arb #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  input  logic [NUM_CH-1:0]            in_last,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [mux4_arb_pkg::SEL_W-1:0] out_sel,
  input  logic                         out_ready
);
  import mux4_arb_pkg::*;

  arb_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [SEL_W-1:0]  r_lock_ch, w_lock_ch_nxt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [SEL_W-1:0]  r_out_sel;

  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_free;
  logic [SEL_W-1:0]  w_ch;
  logic              w_can;
  logic              w_xfer;
  logic              w_last;
  logic [DATA_W-1:0] w_data;

  rr_pick4 u_pick (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // The output slot can take a beat when empty or draining this cycle.
  assign w_free = !r_out_valid || out_ready;

  // While locked, only the packet owner may talk, even across idle gaps.
  assign w_ch  = (r_state == ST_LOCKED) ? r_lock_ch : w_gnt_idx;
  // rst_n gating keeps in_ready low for the whole reset window, not just
  // after the first edge.
  assign w_can = rst_n && w_free && ((r_state == ST_LOCKED) || w_gnt_any);

  assign in_ready = w_can ? (NUM_CH'(1) << w_ch) : '0;
  assign w_xfer   = w_can && in_valid[w_ch];
  assign w_last   = in_last[w_ch];
  assign w_data   = in_data[w_ch*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_ch_nxt = r_lock_ch;
    if (w_xfer) begin
      if (w_last) begin
        // End of packet: release and hand priority to the next channel.
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = inc_wrap(w_ch);
      end else if (r_state == ST_IDLE) begin
        w_state_nxt   = ST_LOCKED;
        w_lock_ch_nxt = w_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  // Payload only loads on a transfer, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_sel   <= w_ch;
    end else if (w_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4_1_stream_arb.sv
module tb_mux4_1_stream_arb;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_valid = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]    in_last = '0;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_sel;
  logic          out_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux4_1_stream_arb #(.DATA_W(DW), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] d, input logic l);
    in_data[k*DW +: DW] = d;
    in_last[k] = l;
    in_valid[k] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    set_ch(1, 8'h5A, 1'b1);
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %0b exp 1", out_valid); else n_pass++;
    @(negedge clk);
    in_valid = 4'b1010;
    set_ch(3, 8'h3C, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL rst_data got %h exp 00", out_data); else n_pass++;
    n_total++; if (out_sel !== 2'd0) $display("FAIL rst_sel got %0d exp 0", out_sel); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_last got %0b exp 0", out_last); else n_pass++;
    n_total++; if (in_ready !== 4'b0000) $display("FAIL rst_in_ready got %b exp 0000", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // rr_ptr was 2 before reset; cleared pointer picks ch1 over ch3.
    n_total++; if (in_ready !== 4'b0010) $display("FAIL rst_ptr_in_ready got %b exp 0010", in_ready); else n_pass++;
  endtask

  task automatic test_rr_per_beat();
    do_reset();
    for (int k = 0; k < 4; k++) set_ch(k, 8'(8'hA0 + k), 1'b1);
    #1;
    n_total++; if (in_ready !== 4'b0001) $display("FAIL rr_first_ready got %b exp 0001", in_ready); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (out_valid !== 1'b1) $display("FAIL rr_valid[%0d] got %0b exp 1", i, out_valid); else n_pass++;
      n_total++; if (out_sel !== 2'(i % 4)) $display("FAIL rr_sel[%0d] got %0d exp %0d", i, out_sel, i % 4); else n_pass++;
      n_total++; if (out_data !== 8'(8'hA0 + (i % 4))) $display("FAIL rr_data[%0d] got %h exp %h", i, out_data, 8'(8'hA0 + (i % 4))); else n_pass++;
    end
    @(negedge clk);
    in_valid = '0;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rr_drain_valid got %0b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_packet_lock();
    do_reset();
    set_ch(1, 8'h11, 1'b0);
    set_ch(2, 8'h22, 1'b1);
    #1;
    n_total++; if (in_ready !== 4'b0010) $display("FAIL lock_ready0 got %b exp 0010", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd1 || out_data !== 8'h11 || out_last !== 1'b0) $display("FAIL lock_beat0 got sel %0d data %h last %0b exp 1 11 0", out_sel, out_data, out_last); else n_pass++;
    @(negedge clk);
    set_ch(1, 8'h12, 1'b0);
    #1;
    n_total++; if (in_ready !== 4'b0010) $display("FAIL lock_ready1 got %b exp 0010", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd1 || out_data !== 8'h12) $display("FAIL lock_beat1 got sel %0d data %h exp 1 12", out_sel, out_data); else n_pass++;
    @(negedge clk);
    set_ch(1, 8'h13, 1'b1);
    #1;
    n_total++; if (in_ready !== 4'b0010) $display("FAIL lock_ready2 got %b exp 0010", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd1 || out_data !== 8'h13 || out_last !== 1'b1) $display("FAIL lock_beat2 got sel %0d data %h last %0b exp 1 13 1", out_sel, out_data, out_last); else n_pass++;
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_total++; if (in_ready !== 4'b0100) $display("FAIL lock_release_ready got %b exp 0100", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd2 || out_data !== 8'h22 || out_last !== 1'b1) $display("FAIL lock_ch2 got sel %0d data %h last %0b exp 2 22 1", out_sel, out_data, out_last); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ch(0, 8'h55, 1'b1);
    step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h55) $display("FAIL bp_load got valid %0b data %h exp 1 55", out_valid, out_data); else n_pass++;
    @(negedge clk);
    in_valid[0] = 1'b0;
    set_ch(1, 8'h66, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready); else n_pass++;
      step();
      n_total++; if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 2'd0 || out_last !== 1'b1)
        $display("FAIL bp_hold[%0d] got valid %0b data %h sel %0d last %0b exp 1 55 0 1", i, out_valid, out_data, out_sel, out_last);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 4'b0010) $display("FAIL bp_release_ready got %b exp 0010", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h66 || out_sel !== 2'd1) $display("FAIL bp_next got valid %0b data %h sel %0d exp 1 66 1", out_valid, out_data, out_sel); else n_pass++;
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    set_ch(2, 8'h20, 1'b1);
    step();
    n_total++; if (out_sel !== 2'd2 || out_data !== 8'h20) $display("FAIL wrap_ch2 got sel %0d data %h exp 2 20", out_sel, out_data); else n_pass++;
    @(negedge clk);
    in_valid = '0;
    set_ch(0, 8'h30, 1'b1);
    set_ch(3, 8'h33, 1'b1);
    #1;
    n_total++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready3 got %b exp 1000", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd3 || out_data !== 8'h33) $display("FAIL wrap_ch3 got sel %0d data %h exp 3 33", out_sel, out_data); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (in_ready !== 4'b0001) $display("FAIL wrap_ready0 got %b exp 0001", in_ready); else n_pass++;
    step();
    n_total++; if (out_sel !== 2'd0 || out_data !== 8'h30) $display("FAIL wrap_ch0 got sel %0d data %h exp 0 30", out_sel, out_data); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_ch(0, 8'h01, 1'b0);
    step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b0) $display("FAIL mid_beat0 got valid %0b data %h last %0b exp 1 01 0", out_valid, out_data, out_last); else n_pass++;
    @(negedge clk);
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b exp 0", out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(2, 8'h2C, 1'b1);
    #1;
    n_total++; if (in_ready !== 4'b0100) $display("FAIL mid_idle_ready got %b exp 0100", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h2C) $display("FAIL mid_ch2 got valid %0b sel %0d data %h exp 1 2 2c", out_valid, out_sel, out_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rr_per_beat();
    test_packet_lock();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/mux4_1_stream_arb.md
Name: mux4_1_stream_arb

Overview:
4-to-1 merge block, the counterpart of the 1-to-4 demux. It collects four valid/ready input streams into one output stream and tags each beat with the 2-bit source index (out_sel), so a downstream demux can re-steer beats by index. Arbitration is round-robin at packet granularity. The output stage is a single registered slot.

Parameters:
- DATA_W, 8, data width per channel.
- NUM_CH, 4, number of input channels. Fixed at 4; other values are not supported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-channel beat valid; bit k belongs to channel k.
- in_data  input  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_last  input  4  per-channel end-of-packet flag.
- in_ready  output  4  per-channel accept; at most one bit is high in any cycle.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output beat data.
- out_last  output  1  end-of-packet flag of the output beat.
- out_sel  output  2  source channel index of the output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - rr_ptr=0, state=IDLE, lock_ch=0.
  - in_ready=0 while reset is asserted.
- free = !out_valid || out_ready. An input beat is accepted only when free=1.
- A transfer occurs on an edge where in_valid[k] && in_ready[k]. The output register then loads in_data[k], in_last[k] and out_sel=k, and sets out_valid=1.
- Latency is 1 cycle from input accept to out_valid. Sustained throughput is 1 beat/cycle with out_ready held at 1.
- If free=1 and no input transfer occurs, out_valid becomes 0 on the next edge.
- While out_valid=1 && out_ready=0, out_data, out_last and out_sel hold stable.
- in_ready is combinational from out_ready, state, rr_ptr and in_valid. There is no skid buffer. Sources must not make in_valid depend on in_ready.
- State machine, 2 states:
  - IDLE:
    - Grant g is the first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, mod 4.
    - in_ready[g]=free; all other bits are 0.
    - On transfer with in_last[g]=0: go to LOCKED, lock_ch<=g.
    - On transfer with in_last[g]=1: stay in IDLE, rr_ptr<=g+1 (2-bit wrap, 3+1=0).
  - LOCKED:
    - in_ready[lock_ch]=free; all other channels get 0 regardless of their valid.
    - On transfer with in_last=1: go to IDLE, rr_ptr<=lock_ch+1.
    - Idle gaps on lock_ch (in_valid=0) keep the state LOCKED. There is no timeout.
- Channels with in_last tied to 1 get pure per-beat round-robin.
- With no requesters, rr_ptr is unchanged.
- Reset mid-packet aborts the open packet and restarts in IDLE with rr_ptr=0.

Decomposition:
- Package mux4_arb_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - State enum: ST_IDLE, ST_LOCKED.
  - Helper function for the 2-bit wrap increment.
- Sub-module rr_pick4 (combinational) takes req[3:0] and ptr[1:0], and outputs gnt_idx[1:0] and gnt_any.
- The top level holds the FSM, rr_ptr, lock_ch and the output register.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately. After release, IDLE with rr_ptr=0.
2. Per-beat round-robin: all in_valid=1, in_last=4'b1111, in_data ch0..3=0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, 1-cycle latency.
3. Packet lock: ch1 sends 0x11,0x12,0x13 with last on the third beat; ch2 valid with 0x22 and last=1 throughout -> out_sel=1 for three beats, then out_sel=2 with data 0x22; in_ready[2]=0 during the lock.
4. Backpressure: out_valid=1 with data 0x55, out_ready=0 for 5 cycles -> out_data, out_sel and out_last stable, in_ready=0. When out_ready=1, the next beat loads in the same cycle.
5. Pointer wrap: grant ch2 (last=1) so rr_ptr=3, then ch0 and ch3 both request -> ch3 granted first, then ch0.
6. Reset mid-packet: ch0 LOCKED after beat 0x01 (last=0), pulse rst_n=0 -> out_valid=0, state IDLE. A subsequent request on ch2 alone is granted immediately.
